key_feedback_driver: RTL and testbench
======================================

Name: key_feedback_driver

Overview:
- Output-side counterpart to the key debouncer: converts 1-cycle key/event pulses back into timed, human-visible board signals.
- Each event drives N active-low blinks on board LEDs, same polarity convention as the KEY pins.
- Sits between the vending controller's event pulses and the board LED/buzzer pins; one shared 20 ms tick paces all timing.

Parameters:
TICK_CYCLES, 1_000_000, clock cycles per tick (20 ms at 50 MHz); tick counter width 20 bits
ON_TICKS, 10, ticks LED is lit per blink (>=1)
OFF_TICKS, 10, ticks LED is dark between blinks (>=1)
BLINK_W, 3, width of blink count field
BUZZ_HALF, 12_500, half-period in cycles of buzzer square wave (2 kHz); used only with BUZZER_EN

Ports:
CLK_50M  input  1  system clock, 50 MHz
RST_N  input  1  asynchronous active-low reset
evt  input  2  per-channel 1-cycle request pulse (e.g. from debouncer key_out)
blink_num  input  BLINK_W  blink count, sampled in any cycle where an evt bit is 1; shared by both channels
led_n  output  2  active-low LED drive, registered; 1 = off
busy  output  2  channel i is in a blink sequence, registered
buzz  output  1  buzzer drive; present only when BUZZER_EN is defined

Behaviour:
- Clock/reset: one clock CLK_50M; RST_N asynchronous, active-low. All flops clear asynchronously.
- Reset values: led_n=2'b11, busy=2'b00, buzz=0, tick counter=0, both channels IDLE, remain=0, phase=0.
- Tick generator: free-running counter 0..TICK_CYCLES-1, wraps to 0. tick=1 for one cycle when counter==TICK_CYCLES-1. It is not restarted by events, so the first ON phase lasts between (ON_TICKS-1)*TICK_CYCLES+1 and ON_TICKS*TICK_CYCLES cycles. This is intended.
- Per-channel FSM, two independent instances. States: IDLE, ON, OFF. Regs: remain[BLINK_W-1:0], phase counter sized for max(ON_TICKS,OFF_TICKS).
- IDLE:
  - evt[i]=1 and blink_num!=0 -> ON; remain<=blink_num, phase<=0.
  - evt[i]=1 and blink_num==0 -> ignored, stays IDLE.
- ON: led_n[i]=0. On tick: if phase==ON_TICKS-1 then phase<=0 and remain<=remain-1; if remain==1 -> IDLE, else -> OFF. Otherwise phase<=phase+1. No tick: hold.
- OFF: led_n[i]=1. On tick: if phase==OFF_TICKS-1 -> ON, phase<=0; else phase<=phase+1.
- Outputs: registered from next state. led_n[i] falls in the cycle after evt[i] is sampled (latency 1). busy[i]=1 from that same cycle until the cycle the FSM re-enters IDLE. led_n[i] and busy[i] change together at sequence end.
- evt[i] while busy[i]=1: ignored; no retrigger, no queueing, remain unchanged.
- evt=2'b11 in one cycle: each idle channel loads the same blink_num.
- evt coincident with a tick: the load wins. Phase starts at 0 and that tick does not advance it.
- Channels never interact except through the shared tick.
- RST_N asserted mid-sequence: immediate return to reset values. No partial blink completes.

Optional Feature:
- Macro BUZZER_EN.
- Defined: port buzz exists. A BUZZ_HALF-cycle counter toggles buzz while any channel is in ON. When no channel is ON, buzz is driven 0 and the counter is cleared.
- Not defined: no buzz port, no buzzer counter or logic. All other behaviour is identical.

Test Plan:
All scenarios use TICK_CYCLES=4, ON_TICKS=2, OFF_TICKS=1, BUZZ_HALF=2.
1. Release reset; evt=2'b01 with blink_num=2 -> led_n[0] low for 2 ticks, high 1 tick, low 2 ticks, then high. busy[0]=1 throughout and drops with the final led_n[0] rise. led_n[1]=1 and busy[1]=0 the whole time.
2. evt=2'b10 with blink_num=0 -> no change: led_n=2'b11, busy=2'b00.
3. Channel 0 busy with blink_num=3; pulse evt[0] again with blink_num=1 mid-sequence -> still exactly 3 blinks; second request ignored.
4. evt=2'b11 with blink_num=1 -> both LEDs low from the next cycle for 2 ticks. Both return high and busy clears in the same cycle.
5. Assert RST_N low during channel 0's ON phase -> led_n=2'b11 and busy=0 immediately (asynchronous). After release, the channel accepts a new evt normally.
6. With BUZZER_EN: during any ON phase buzz toggles every 2 cycles; buzz=0 in OFF and IDLE. Without BUZZER_EN: the build has no buzz port.

Source files
------------

// File: rtl/key_feedback_driver.sv
// rtl/key_feedback_driver.sv - turns 1-cycle event pulses into timed active-low LED blink sequences
// Optional buzzer output and square-wave generator enabled by defining BUZZER_EN.
module key_feedback_driver #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int ON_TICKS    = 10,
    parameter int OFF_TICKS   = 10,
    parameter int BLINK_W     = 3,
    parameter int BUZZ_HALF   = 12_500
) (
    input  logic               CLK_50M,
    input  logic               RST_N,
    input  logic [1:0]         evt,
    input  logic [BLINK_W-1:0] blink_num,
    output logic [1:0]         led_n,
`ifdef BUZZER_EN
    output logic               buzz,
`endif
    output logic [1:0]         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0]    PH_ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0]    PH_OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [BLINK_W-1:0] REMAIN_ONE  = BLINK_W'(1);

    logic [19:0] tick_cnt;
    logic        tick;

    logic [1:0]         state      [2];
    logic [1:0]         state_nxt  [2];
    logic [BLINK_W-1:0] remain     [2];
    logic [BLINK_W-1:0] remain_nxt [2];
    logic [PH_W-1:0]    phase      [2];
    logic [PH_W-1:0]    phase_nxt  [2];

    // Free-running pacing tick shared by both channels; never restarted by events.
    assign tick = (tick_cnt == 20'(TICK_CYCLES - 1));

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 20'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i]  = state[i];
            remain_nxt[i] = remain[i];
            phase_nxt[i]  = phase[i];
            case (state[i])
                // IDLE ignores tick, so a load coincident with a tick starts at phase 0.
                ST_IDLE: begin
                    if (evt[i] && (blink_num != '0)) begin
                        state_nxt[i]  = ST_ON;
                        remain_nxt[i] = blink_num;
                        phase_nxt[i]  = '0;
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        if (phase[i] == PH_ON_LAST) begin
                            phase_nxt[i]  = '0;
                            remain_nxt[i] = remain[i] - REMAIN_ONE;
                            state_nxt[i]  = (remain[i] == REMAIN_ONE) ? ST_IDLE : ST_OFF;
                        end else begin
                            phase_nxt[i] = phase[i] + PH_W'(1);
                        end
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (phase[i] == PH_OFF_LAST) begin
                            state_nxt[i] = ST_ON;
                            phase_nxt[i] = '0;
                        end else begin
                            phase_nxt[i] = phase[i] + PH_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from next state so led_n and busy move together.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                state[i]  <= ST_IDLE;
                remain[i] <= '0;
                phase[i]  <= '0;
            end
            led_n <= 2'b11;
            busy  <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i]  <= state_nxt[i];
                remain[i] <= remain_nxt[i];
                phase[i]  <= phase_nxt[i];
                led_n[i]  <= (state_nxt[i] != ST_ON);
                busy[i]   <= (state_nxt[i] != ST_IDLE);
            end
        end
    end

`ifdef BUZZER_EN
    localparam int BZ_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;

    logic [BZ_W-1:0] buzz_cnt;
    logic            any_on_nxt;

    assign any_on_nxt = (state_nxt[0] == ST_ON) || (state_nxt[1] == ST_ON);

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
        end else if (!any_on_nxt) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
        end else if (buzz_cnt == BZ_W'(BUZZ_HALF - 1)) begin
            buzz_cnt <= '0;
            buzz     <= ~buzz;
        end else begin
            buzz_cnt <= buzz_cnt + BZ_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_key_feedback_driver.sv
// tb/tb_key_feedback_driver.sv - directed self-checking bench for key_feedback_driver
// Buzzer checks are compiled in only when BUZZER_EN is defined.
module tb_key_feedback_driver;

    logic       CLK_50M = 1'b0;
    logic       RST_N   = 1'b0;
    logic [1:0] evt     = 2'b00;
    logic [2:0] blink_num = 3'd0;
    logic [1:0] led_n;
    logic [1:0] busy;
`ifdef BUZZER_EN
    logic       buzz;
`endif

    int n_vec = 0;
    int n_err = 0;

    key_feedback_driver #(
        .TICK_CYCLES(4),
        .ON_TICKS   (2),
        .OFF_TICKS  (1),
        .BLINK_W    (3),
        .BUZZ_HALF  (2)
    ) dut (
        .CLK_50M  (CLK_50M),
        .RST_N    (RST_N),
        .evt      (evt),
        .blink_num(blink_num),
        .led_n    (led_n),
`ifdef BUZZER_EN
        .buzz     (buzz),
`endif
        .busy     (busy)
    );

    always #5 CLK_50M = ~CLK_50M;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK_50M);
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_led", {2'b0, led_n}, 4'h3);
        chk("rst_busy", {2'b0, busy}, 4'h0);
`ifdef BUZZER_EN
        chk("rst_buzz", {3'b0, buzz}, 4'h0);
`endif

        // 1: two blinks on channel 0; ticks land on edges 4, 8, 12, ...
        RST_N = 1'b1;
        evt = 2'b01; blink_num = 3'd2;
        step(1);
        evt = 2'b00;
        chk("s1_e1_led", {2'b0, led_n}, 4'h2);
        chk("s1_e1_busy", {2'b0, busy}, 4'h1);
        step(1);
`ifdef BUZZER_EN
        chk("s1_e2_buzz", {3'b0, buzz}, 4'h1);
`endif
        step(2);
`ifdef BUZZER_EN
        chk("s1_e4_buzz", {3'b0, buzz}, 4'h0);
`endif
        step(3);
        chk("s1_e7_led", {2'b0, led_n}, 4'h2);
        step(1);
        chk("s1_e8_led", {2'b0, led_n}, 4'h3);
        chk("s1_e8_busy", {2'b0, busy}, 4'h1);
`ifdef BUZZER_EN
        chk("s1_e8_buzz", {3'b0, buzz}, 4'h0);
`endif
        step(3);
        chk("s1_e11_led", {2'b0, led_n}, 4'h3);
        step(1);
        chk("s1_e12_led", {2'b0, led_n}, 4'h2);
        step(7);
        chk("s1_e19_led", {2'b0, led_n}, 4'h2);
        chk("s1_e19_busy", {2'b0, busy}, 4'h1);
        step(1);
        chk("s1_e20_led", {2'b0, led_n}, 4'h3);
        chk("s1_e20_busy", {2'b0, busy}, 4'h0);

        // 2: zero blink count is ignored
        evt = 2'b10; blink_num = 3'd0;
        step(1);
        evt = 2'b00;
        chk("s2_led", {2'b0, led_n}, 4'h3);
        chk("s2_busy", {2'b0, busy}, 4'h0);
        step(3);
        chk("s2_later_busy", {2'b0, busy}, 4'h0);

        // 3: three blinks, retrigger with blink_num=1 mid-sequence is ignored
        evt = 2'b01; blink_num = 3'd3;
        step(1);
        evt = 2'b00;
        chk("s3_f1_led", {2'b0, led_n}, 4'h2);
        step(4);
        evt = 2'b01; blink_num = 3'd1;
        step(1);
        evt = 2'b00;
        chk("s3_f6_led", {2'b0, led_n}, 4'h2);
        step(2);
        chk("s3_f8_led", {2'b0, led_n}, 4'h3);
        chk("s3_f8_busy", {2'b0, busy}, 4'h1);
        step(4);
        chk("s3_f12_led", {2'b0, led_n}, 4'h2);
        step(8);
        chk("s3_f20_led", {2'b0, led_n}, 4'h3);
        chk("s3_f20_busy", {2'b0, busy}, 4'h1);
        step(4);
        chk("s3_f24_led", {2'b0, led_n}, 4'h2);
        step(7);
        chk("s3_f31_led", {2'b0, led_n}, 4'h2);
        step(1);
        chk("s3_f32_led", {2'b0, led_n}, 4'h3);
        chk("s3_f32_busy", {2'b0, busy}, 4'h0);

        // 4: both channels load together and finish together
        evt = 2'b11; blink_num = 3'd1;
        step(1);
        evt = 2'b00;
        chk("s4_g1_led", {2'b0, led_n}, 4'h0);
        chk("s4_g1_busy", {2'b0, busy}, 4'h3);
        step(6);
        chk("s4_g7_led", {2'b0, led_n}, 4'h0);
        step(1);
        chk("s4_g8_led", {2'b0, led_n}, 4'h3);
        chk("s4_g8_busy", {2'b0, busy}, 4'h0);

        // Load coincident with a tick: the tick must not advance the new phase
        step(3);
        evt = 2'b01; blink_num = 3'd1;
        step(1);
        evt = 2'b00;
        chk("tk_g12_led", {2'b0, led_n}, 4'h2);
        step(4);
        chk("tk_g16_led", {2'b0, led_n}, 4'h2);
        step(3);
        chk("tk_g19_busy", {2'b0, busy}, 4'h1);
        step(1);
        chk("tk_g20_led", {2'b0, led_n}, 4'h3);
        chk("tk_g20_busy", {2'b0, busy}, 4'h0);

        // 5: asynchronous reset mid-ON, then normal reuse
        evt = 2'b01; blink_num = 3'd2;
        step(1);
        evt = 2'b00;
        chk("s5_on_led", {2'b0, led_n}, 4'h2);
        step(1);
        #2 RST_N = 1'b0;
        #1;
        chk("s5_rst_led", {2'b0, led_n}, 4'h3);
        chk("s5_rst_busy", {2'b0, busy}, 4'h0);
        step(1);
        RST_N = 1'b1;
        evt = 2'b01; blink_num = 3'd1;
        step(1);
        evt = 2'b00;
        chk("s5_j1_led", {2'b0, led_n}, 4'h2);
        chk("s5_j1_busy", {2'b0, busy}, 4'h1);
        step(6);
        chk("s5_j7_led", {2'b0, led_n}, 4'h2);
        step(1);
        chk("s5_j8_led", {2'b0, led_n}, 4'h3);
        chk("s5_j8_busy", {2'b0, busy}, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
